// File: rtl/track_pkg.sv
// Shared types, colour tables and lane geometry for the track renderer and its collision scanner.
package track_pkg;

    localparam int POS_W   = 10;
    localparam int COLOR_W = 12;

    typedef struct packed {
        logic [1:0]       otype;
        logic [POS_W-1:0] pos;
        logic [1:0]       lane;
        logic             active;
    } obstacle_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

    // Index 0 is the rightmost element of each packed table.
    localparam logic [3:0][COLOR_W-1:0] TYPE_COLORS = {12'hFFF, 12'hFF0, 12'h0F0, 12'hF00};
    localparam logic [3:0][COLOR_W-1:0] LANE_COLORS = {12'h00F, 12'h00C, 12'h008, 12'h004};

    function automatic int lane_height(int screen_h, int lanes);
        return screen_h / lanes;
    endfunction

    function automatic int obstacle_width(int screen_h, int lanes, int margin);
        return screen_h / lanes - 2 * margin;
    endfunction

endpackage

// File: rtl/track_renderer_if.sv
// Pixel timing, obstacle table and player inputs plus the rendered pixel and collision outputs.
interface track_renderer_if
    import track_pkg::*;
#(
    parameter int NUM_OBSTACLES = 10
);
    logic [10:0]                   hcount;
    logic [9:0]                    vcount;
    logic                          hsync, vsync, blank;
    obstacle_t [NUM_OBSTACLES-1:0] obstacles;
    logic [1:0]                    player_lane;
    logic [POS_W-1:0]              player_x;
    logic [COLOR_W-1:0]            rgb;
    logic                          hsync_out, vsync_out, blank_out;
    logic                          collision, collision_valid;

    modport master (
        output hcount, vcount, hsync, vsync, blank, obstacles, player_lane, player_x,
        input  rgb, hsync_out, vsync_out, blank_out, collision, collision_valid
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, blank, obstacles, player_lane, player_x,
        output rgb, hsync_out, vsync_out, blank_out, collision, collision_valid
    );
endinterface

// File: rtl/obstacle_collision_scan.sv
// Walks the shadow obstacle table one slot per cycle after each snapshot and reports player overlap.
module obstacle_collision_scan
    import track_pkg::*;
#(
    parameter int NUM_OBSTACLES = 10,
    parameter int NUM_LANES     = 3,
    parameter int OBS_W         = 224
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          snap_i,
    input  obstacle_t [NUM_OBSTACLES-1:0] slots_i,
    input  logic [1:0]                    p_lane_i,
    input  logic [POS_W-1:0]              p_x_i,
    output logic                          collision_o,
    output logic                          collision_valid_o
);
    localparam int IDX_W = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d, coll_q, coll_d;
    obstacle_t        slot;
    logic [POS_W:0]   p_end, o_end;
    logic             slot_hit;

    assign slot  = slots_i[idx_q];
    assign p_end = {1'b0, p_x_i} + (POS_W+1)'(OBS_W);
    assign o_end = {1'b0, slot.pos} + (POS_W+1)'(OBS_W);
    // Half-open ranges [pos,pos+W) and [p_x,p_x+W) overlap; sums carry one extra bit so nothing wraps.
    assign slot_hit = slot.active && (slot.lane == p_lane_i) && (int'(p_lane_i) < NUM_LANES) &&
                      (int'(slot.pos) < int'(p_end)) && (int'(p_x_i) < int'(o_end));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        coll_d  = coll_q;
        unique case (state_q)
            IDLE: ;
            SCAN: begin
                acc_d = acc_q | slot_hit;
                if (idx_q == IDX_W'(NUM_OBSTACLES - 1)) begin
                    state_d = DONE;
                    coll_d  = acc_q | slot_hit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A fresh snapshot always restarts the walk from slot 0.
        if (snap_i) begin
            state_d = SCAN;
            idx_d   = '0;
            acc_d   = 1'b0;
        end
    end

    assign collision_o       = coll_q;
    assign collision_valid_o = (state_q == DONE);

endmodule

// File: rtl/track_renderer.sv
// Lane/obstacle pixel generator: per-frame shadow table, 3-stage pixel pipeline, delayed syncs.
module track_renderer
    import track_pkg::*;
#(
    parameter int SCREEN_WIDTH    = 1024,
    parameter int SCREEN_HEIGHT   = 768,
    parameter int NUM_LANES       = 3,
    parameter int NUM_OBSTACLES   = 10,
    parameter int OBSTACLE_MARGIN = 16
) (
    input logic              system_clock_in,
    input logic              system_reset_in,
    track_renderer_if.slave  bus
);
    localparam int LANE_HEIGHT = lane_height(SCREEN_HEIGHT, NUM_LANES);
    localparam int OBS_W       = obstacle_width(SCREEN_HEIGHT, NUM_LANES, OBSTACLE_MARGIN);

    logic clk, rst;
    assign clk = system_clock_in;
    assign rst = system_reset_in;

    obstacle_t [NUM_OBSTACLES-1:0] shadow_q;
    logic [1:0]                    p_lane_q;
    logic [POS_W-1:0]              p_x_q;
    logic                          snap;

    assign snap = (bus.hcount == 11'd0) && (int'(bus.vcount) == SCREEN_HEIGHT);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            p_lane_q <= '0;
            p_x_q    <= '0;
        end else if (snap) begin
            shadow_q <= bus.obstacles;
            p_lane_q <= bus.player_lane;
            p_x_q    <= bus.player_x;
        end
    end

    // S1: lane band via compare chain, margin and blank flags.
    logic [1:0]  lane1_d, lane1_q, lane2_q;
    logic        margin1_d, margin1_q, margin2_q;
    logic        blank1_d, blank1_q, blank2_q;
    logic [10:0] h1_q;
    logic [9:0]  base, off;

    always_comb begin
        lane1_d = '0;
        base    = '0;
        for (int i = 1; i < NUM_LANES; i++) begin
            if (int'(bus.vcount) >= i * LANE_HEIGHT) begin
                lane1_d = 2'(i);
                base    = 10'(i * LANE_HEIGHT);
            end
        end
        off       = bus.vcount - base;
        margin1_d = (int'(off) < OBSTACLE_MARGIN) || (int'(off) >= LANE_HEIGHT - OBSTACLE_MARGIN);
        // Anything outside the active area renders black.
        blank1_d  = bus.blank || (int'(bus.vcount) >= SCREEN_HEIGHT) ||
                    (int'(bus.hcount) >= SCREEN_WIDTH);
    end

    // S2: per-slot hit, then lowest-index winner captured with its type.
    logic [NUM_OBSTACLES-1:0] hit;
    logic                     hit_any_d, hit_any_q;
    logic [1:0]               hit_type_d, hit_type_q;

    for (genvar g = 0; g < NUM_OBSTACLES; g++) begin : g_hit
        logic [POS_W:0] x_end;
        assign x_end  = {1'b0, shadow_q[g].pos} + (POS_W+1)'(OBS_W);
        assign hit[g] = shadow_q[g].active && (shadow_q[g].lane == lane1_q) &&
                        (int'(h1_q) >= int'(shadow_q[g].pos)) && (int'(h1_q) < int'(x_end));
    end

    always_comb begin
        hit_any_d  = 1'b0;
        hit_type_d = '0;
        for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any_d  = 1'b1;
                hit_type_d = shadow_q[i].otype;
            end
        end
    end

    // S3: colour select.
    logic [COLOR_W-1:0] rgb_d, rgb_q;
    always_comb begin
        rgb_d = '0;
        if (!blank2_q)
            rgb_d = (margin2_q || !hit_any_q) ? LANE_COLORS[lane2_q] : TYPE_COLORS[hit_type_q];
    end

    logic [2:0] hs_q, vs_q, bl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane1_q    <= '0;
            margin1_q  <= 1'b0;
            blank1_q   <= 1'b1;
            h1_q       <= '0;
            lane2_q    <= '0;
            margin2_q  <= 1'b0;
            blank2_q   <= 1'b1;
            hit_any_q  <= 1'b0;
            hit_type_q <= '0;
            rgb_q      <= '0;
            hs_q       <= '0;
            vs_q       <= '0;
            bl_q       <= '1;
        end else begin
            lane1_q    <= lane1_d;
            margin1_q  <= margin1_d;
            blank1_q   <= blank1_d;
            h1_q       <= bus.hcount;
            lane2_q    <= lane1_q;
            margin2_q  <= margin1_q;
            blank2_q   <= blank1_q;
            hit_any_q  <= hit_any_d;
            hit_type_q <= hit_type_d;
            rgb_q      <= rgb_d;
            hs_q       <= {hs_q[1:0], bus.hsync};
            vs_q       <= {vs_q[1:0], bus.vsync};
            bl_q       <= {bl_q[1:0], bus.blank};
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hs_q[2];
    assign bus.vsync_out = vs_q[2];
    assign bus.blank_out = bl_q[2];

    obstacle_collision_scan #(
        .NUM_OBSTACLES (NUM_OBSTACLES),
        .NUM_LANES     (NUM_LANES),
        .OBS_W         (OBS_W)
    ) u_scan (
        .clk_i             (clk),
        .rst_i             (rst),
        .snap_i            (snap),
        .slots_i           (shadow_q),
        .p_lane_i          (p_lane_q),
        .p_x_i             (p_x_q),
        .collision_o       (bus.collision),
        .collision_valid_o (bus.collision_valid)
    );

endmodule
